sfp_array: RTL and testbench
============================

Name: sfp_array

Overview:
- Column-parallel special-function processor; sits between the output FIFO (OFIFO) and the dual-port PSUM SRAM.
- Runs one pass over a tile of `len` consecutive PSUM rows. For each row it reads from SRAM, combines with the OFIFO row, and writes the result back.
- Supported operations: load, accumulate, accumulate+ReLU, ReLU-only. Arithmetic is signed 2's-complement.
- Address generation and handshakes are internal; the controller only issues start/op/base/len and waits for done.

Parameters:
- col, 8, number of lanes (array columns)
- psum_bw, 16, per-lane partial-sum width, signed
- addr_bw, 11, PSUM SRAM address width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches op/base_addr/len; honoured only in IDLE
- op  input  2  00 LOAD, 01 ACC, 10 ACC_RELU, 11 RELU
- base_addr  input  addr_bw  first PSUM row of the tile
- len  input  addr_bw+1  row count, 0..2^addr_bw
- ofifo_valid  input  1  OFIFO non-empty; show-ahead data on ofifo_in
- ofifo_in  input  col*psum_bw  OFIFO row, lane i at [i*psum_bw +: psum_bw]
- ofifo_rd  output  1  pop strobe
- sram_rd_en  output  1  PSUM read enable
- sram_rd_addr  output  addr_bw  read address
- psum_in  input  col*psum_bw  SRAM read data, valid 1 cycle after sram_rd_en
- sram_wr_en  output  1  PSUM write enable
- sram_wr_addr  output  addr_bw  write address
- sram_wr_data  output  col*psum_bw  write data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; both pipeline valid bits cleared; counters 0. Reset asserted mid-pass aborts the pass immediately: no further write and no done pulse.
- FSM states:
  - IDLE: on start, go to RUN. If len==0, go to DONE instead.
  - RUN: issue rows. After the issue with index len-1, go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored when not in IDLE.
- Issue (stage 0), RUN state:
  - needs_fifo = (op != RELU); needs_rd = (op != LOAD).
  - A row issues when !needs_fifo || ofifo_valid.
  - On issue: ofifo_rd = needs_fifo; sram_rd_en = needs_rd; sram_rd_addr = base_addr + idx; OFIFO row and address are registered into stage 1.
  - OFIFO empty: no issue, no pop, no read. This is a stall only; rows already in the pipe keep draining.
- Stage 1 (issue+1): per lane, the result is computed from psum_in (SRAM data) and the registered OFIFO row:
  - LOAD: f
  - ACC: p+f
  - ACC_RELU: max(p+f, 0)
  - RELU: max(p, 0)
  - The result is registered into stage 2.
- Stage 2 (issue+2): sram_wr_en=1, sram_wr_addr=the row's address, sram_wr_data=the stage-2 register.
- Throughput: one row per cycle. The last write lands at last_issue+2; done pulses at last_issue+3.
- Hazards: within a pass, reads and writes always target distinct addresses. Passes do not overlap because DONE only follows a fully drained pipe.
- Address wrap: base_addr+idx wraps modulo 2^addr_bw. len = 2^addr_bw is legal.
- Sum width: p+f is computed at psum_bw+1 bits and then reduced to psum_bw by the SFP_SAT_EN rule.
- ReLU compares against the signed value. Most-negative input → 0.
- Lanes are fully independent.

Optional Feature:
- Macro: SFP_SAT_EN.
- Defined: a sum outside the psum_bw range clamps to the signed max or min, per lane.
- Undefined: the sum truncates to the low psum_bw bits (2's-complement wrap).
- LOAD and RELU results are identical with and without the macro.

Decomposition:
- sfp_pkg holds: op encoding enum (SFP_LOAD/ACC/ACC_RELU/RELU), FSM state enum, signed saturate function.
- Sub-module sfp_lane: one lane's combinational add/saturate/ReLU (inputs p, f, op; output result). sfp_array instantiates col copies via generate and owns the FSM, counters and pipeline registers.

Test Plan:
- LOAD, base=5, len=3, OFIFO always valid with rows R0..R2 → pops at t+1..t+3; writes addr 5,6,7 with R0..R2 at t+3..t+5; done at t+6; sram_rd_en never asserted.
- ACC, lane 0 p=100, f=-30 → write 70. ACC_RELU with p=10, f=-30 → write 0. RELU with p=-5 → 0; p=7 → 7, no pops.
- ACC, p=32767, f=1: with SFP_SAT_EN → 32767; without → -32768. Same for p=-32768, f=-1 → -32768 / 32767.
- ofifo_valid low for 4 cycles mid-pass, len=6 → no pops or reads while low; exactly 6 writes, consecutive addresses, done once.
- len=0 → done one cycle after start; no rd/wr/pop. base=2047, len=2 → writes addr 2047 then 0.
- reset asserted in the cycle a row is in stage 1 → no further write, no done; all outputs 0; next start executes normally.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types for the sfp_array special-function processor.
// SFP_SAT_EN selects saturating sums instead of wrapping sums.
package sfp_pkg;

  typedef enum logic [1:0] {
    SFP_LOAD     = 2'b00,
    SFP_ACC      = 2'b01,
    SFP_ACC_RELU = 2'b10,
    SFP_RELU     = 2'b11
  } sfp_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sfp_state_e;

  localparam int SFP_SUM_W = 33;

  // Clamp a signed value into the signed range of bw bits.
  function automatic logic signed [SFP_SUM_W-1:0] sfp_sat(
    input logic signed [SFP_SUM_W-1:0] s,
    input int                          bw
  );
    logic signed [SFP_SUM_W-1:0] hi;
    logic signed [SFP_SUM_W-1:0] lo;
    hi = $signed((SFP_SUM_W'(1) << (bw - 1)) - SFP_SUM_W'(1));
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One lane: add, reduce (wrap or SFP_SAT_EN clamp) and ReLU.
// Purely combinational; the array registers the result.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] p,
  input  logic [psum_bw-1:0] f,
  input  logic [1:0]         op,
  output logic [psum_bw-1:0] result
);

  logic signed [psum_bw:0] sum;
  logic [psum_bw-1:0]      red;

  assign sum = $signed({p[psum_bw-1], p})
             + $signed({f[psum_bw-1], f});

`ifdef SFP_SAT_EN
  logic signed [SFP_SUM_W-1:0] clamped;
  logic                        unused_hi;

  assign clamped   = sfp_sat(SFP_SUM_W'(sum), psum_bw);
  assign red       = clamped[psum_bw-1:0];
  assign unused_hi = ^clamped[SFP_SUM_W-1:psum_bw];
`else
  assign red = sum[psum_bw-1:0];
`endif

  always_comb begin
    result = red;
    unique case (1'b1)
      op == SFP_LOAD:     result = f;
      op == SFP_ACC:      result = red;
      op == SFP_ACC_RELU: result = red[psum_bw-1] ? '0 : red;
      default:            result = p[psum_bw-1] ? '0 : p;
    endcase
  end

endmodule

// File: rtl/sfp_array.sv
// Column-parallel SFP between OFIFO and PSUM SRAM: issue, compute, write.
// Build option SFP_SAT_EN: saturate sums instead of wrapping them.
module sfp_array
  import sfp_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw:0]         len,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_in,
  output logic                     ofifo_rd,
  output logic                     sram_rd_en,
  output logic [addr_bw-1:0]       sram_rd_addr,
  input  logic [col*psum_bw-1:0]   psum_in,
  output logic                     sram_wr_en,
  output logic [addr_bw-1:0]       sram_wr_addr,
  output logic [col*psum_bw-1:0]   sram_wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int W = col * psum_bw;

  sfp_state_e         state;
  sfp_state_e         state_nx;
  sfp_op_e            op_q;
  logic [addr_bw-1:0] base_q;
  logic [addr_bw:0]   len_q;
  logic [addr_bw:0]   idx;

  logic               needs_fifo;
  logic               needs_rd;
  logic               issue;
  logic               last;
  logic [addr_bw-1:0] rd_addr;

  logic               s1_v;
  logic [addr_bw-1:0] s1_addr;
  logic [W-1:0]       s1_f;
  logic               s2_v;
  logic [addr_bw-1:0] s2_addr;
  logic [W-1:0]       s2_d;
  logic [W-1:0]       res;

  assign needs_fifo = op_q != SFP_RELU;
  assign needs_rd   = op_q != SFP_LOAD;
  assign issue      = (state == S_RUN)
                   && (!needs_fifo || ofifo_valid);
  assign last       = issue && (idx == len_q - 1'b1);
  assign rd_addr    = base_q + idx[addr_bw-1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nx = (len == '0) ? S_DONE : S_RUN;
      S_RUN:
        if (last) state_nx = S_DRAIN;
      // s2 retires this cycle, so an empty s1 means the pipe is drained
      S_DRAIN:
        if (!s1_v) state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= SFP_LOAD;
      base_q <= '0;
      len_q  <= '0;
      idx    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q   <= sfp_op_e'(op);
        base_q <= base_addr;
        len_q  <= len;
        idx    <= '0;
      end else if (issue) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_addr <= '0;
      s1_f    <= '0;
      s2_v    <= 1'b0;
      s2_addr <= '0;
      s2_d    <= '0;
    end else begin
      s1_v <= issue;
      if (issue) begin
        s1_addr <= rd_addr;
        s1_f    <= ofifo_in;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_addr <= s1_addr;
        s2_d    <= res;
      end
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(
      .psum_bw(psum_bw)
    ) u_lane (
      .p      (psum_in[i*psum_bw +: psum_bw]),
      .f      (s1_f[i*psum_bw +: psum_bw]),
      .op     (op_q),
      .result (res[i*psum_bw +: psum_bw])
    );
  end

  assign ofifo_rd     = issue && needs_fifo;
  assign sram_rd_en   = issue && needs_rd;
  assign sram_rd_addr = sram_rd_en ? rd_addr : '0;
  assign sram_wr_en   = s2_v;
  assign sram_wr_addr = s2_addr;
  assign sram_wr_data = s2_d;
  assign busy         = state != S_IDLE;
  assign done         = state == S_DONE;

endmodule

// File: tb/tb_sfp_array.sv
// Scoreboard bench for sfp_array: SRAM/OFIFO models plus a row-level
// reference computed from the op rules; honours SFP_SAT_EN.
module tb_sfp_array;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int ABW   = 11;
  localparam int W     = COL * PBW;
  localparam int DEPTH = 2048;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = '0;
  logic [ABW-1:0] base_addr = '0;
  logic [ABW:0]   len = '0;
  logic           ofifo_valid = 1'b0;
  logic [W-1:0]   ofifo_in = '0;
  logic           ofifo_rd;
  logic           sram_rd_en;
  logic [ABW-1:0] sram_rd_addr;
  logic [W-1:0]   psum_in = '0;
  logic           sram_wr_en;
  logic [ABW-1:0] sram_wr_addr;
  logic [W-1:0]   sram_wr_data;
  logic           busy;
  logic           done;

  sfp_array #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .base_addr    (base_addr),
    .len          (len),
    .ofifo_valid  (ofifo_valid),
    .ofifo_in     (ofifo_in),
    .ofifo_rd     (ofifo_rd),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .psum_in      (psum_in),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [ABW-1:0] a;
    logic [W-1:0]   d;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] rows [$];
  exp_t         exp_q [$];

  int             tot_wr = 0;
  int             tot_pop = 0;
  int             tot_rd = 0;
  int             tot_done = 0;
  int             done_cyc = 0;
  int             rd_snap = 0;
  int             pass_base = 0;
  int             cur_op = 0;
  bit             pend_pop = 0;
  bit             pend_rd = 0;
  logic [ABW-1:0] pend_addr = '0;
  int             stall_lo = -1;
  int             stall_hi = -1;
  bit             rand_gate = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each lane follows the op rules with integer arithmetic.
  function automatic logic [W-1:0] model_row(input int o,
      input logic [W-1:0] p, input logic [W-1:0] f);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      int pv;
      int fv;
      int s;
      int v;
      pv = int'($signed(p[i*PBW +: PBW]));
      fv = int'($signed(f[i*PBW +: PBW]));
      s  = pv + fv;
`ifdef SFP_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`else
      s = ((s + 32768) & 65535) - 32768;
`endif
      case (o)
        0:       v = fv;
        1:       v = s;
        2:       v = (s < 0) ? 0 : s;
        default: v = (pv < 0) ? 0 : pv;
      endcase
      r[i*PBW +: PBW] = 16'(v);
    end
    return r;
  endfunction

  function automatic logic [PBW-1:0] rnd_lane();
    case ($urandom_range(0, 5))
      0:       return 16'h7fff;
      1:       return 16'h8000;
      2:       return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = rnd_lane();
    return r;
  endfunction

  // SRAM and OFIFO models: apply last cycle's pop/read after the edge.
  always @(posedge clk) begin
    logic [W-1:0] junk;
    bit           gate;
    #2;
    if (pend_pop && fifo_q.size() > 0) junk = fifo_q.pop_front();
    psum_in = pend_rd ? mem[pend_addr]
                      : {$urandom, $urandom, $urandom, $urandom};
    gate = !(cyc >= stall_lo && cyc < stall_hi)
        && (!rand_gate || $urandom_range(0, 3) != 0);
    ofifo_valid = gate && fifo_q.size() > 0;
    ofifo_in = (fifo_q.size() > 0) ? fifo_q[0]
             : {$urandom, $urandom, $urandom, $urandom};
  end

  // Monitor: pops the scoreboard on every write, audits pops and reads.
  always @(negedge clk) begin
    if (reset) begin
      pend_pop = 0;
      pend_rd  = 0;
    end else begin
      if (sram_wr_en) begin
        tot_wr++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, none expected",
                   sram_wr_addr, sram_wr_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", W'(sram_wr_addr), W'(e.a));
          chk("wr_data", sram_wr_data, e.d);
        end
        mem[sram_wr_addr] = sram_wr_data;
      end
      if (ofifo_rd) begin
        tot_pop++;
        chk("pop_when_valid", W'(ofifo_valid), W'(1));
      end
      if (sram_rd_en) begin
        tot_rd++;
        chk("rd_addr", W'(sram_rd_addr),
            W'((pass_base + tot_rd - 1 - rd_snap) % DEPTH));
        chk("rd_allowed", W'(cur_op != 0 && (ofifo_valid || cur_op == 3)),
            W'(1));
      end
      pend_pop  = ofifo_rd;
      pend_rd   = sram_rd_en;
      pend_addr = sram_rd_addr;
      if (done) begin
        tot_done++;
        done_cyc = cyc;
        chk("drained_at_done", W'(exp_q.size()), W'(0));
      end
    end
  end

  task automatic run_pass(input string tag, input int o, input int b,
                          input int n, input bit stall, input bit rg);
    int           s_wr;
    int           s_pop;
    int           s_rd;
    int           s_done;
    int           t0;
    int           bound;
    bit           nf;
    bit           nr;
    logic [W-1:0] f;
    nf = (o != 3);
    nr = (o != 0);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (b + k) % DEPTH;
      if (k >= rows.size()) rows.push_back(rnd_row());
      f = nf ? rows[k] : '0;
      exp_q.push_back('{a: ABW'(a), d: model_row(o, mem[a], f)});
      if (nf) fifo_q.push_back(rows[k]);
    end
    rows.delete();
    s_wr   = tot_wr;
    s_pop  = tot_pop;
    s_rd   = tot_rd;
    s_done = tot_done;
    rand_gate = rg;
    @(negedge clk);
    cur_op    = o;
    pass_base = b;
    rd_snap   = tot_rd;
    start     = 1'b1;
    op        = 2'(o);
    base_addr = ABW'(b);
    len       = (ABW+1)'(n);
    t0        = cyc;
    if (stall) begin
      stall_lo = cyc + 3;
      stall_hi = cyc + 7;
    end
    @(negedge clk);
    start = 1'b0;
    bound = n * 8 + 64;
    while (tot_done == s_done && bound > 0) begin
      @(negedge clk);
      #1;
      bound--;
    end
    if (tot_done == s_done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done, required within %0d cycles",
               tag, n * 8 + 64);
    end else if (!stall && !rg) begin
      chk({tag, "_done_latency"}, W'(done_cyc - t0),
          W'((n == 0) ? 1 : n + 3));
    end
    @(negedge clk);
    #1;
    chk({tag, "_writes"}, W'(tot_wr - s_wr), W'(n));
    chk({tag, "_pops"}, W'(tot_pop - s_pop), W'(nf ? n : 0));
    chk({tag, "_reads"}, W'(tot_rd - s_rd), W'(nr ? n : 0));
    chk({tag, "_done_count"}, W'(tot_done - s_done), W'(1));
    chk({tag, "_fifo_left"}, W'(fifo_q.size()), W'(0));
    chk({tag, "_idle"}, W'(busy), W'(0));
    stall_lo  = -1;
    stall_hi  = -1;
    rand_gate = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, W'({ofifo_rd, sram_rd_en, sram_wr_en, busy, done}),
        W'(0));
    chk({tag, "_addr"}, W'({sram_rd_addr, sram_wr_addr}), W'(0));
    chk({tag, "_data"}, sram_wr_data, W'(0));
  endtask

  initial begin
    logic [W-1:0] r;
    int           s_wr;
    int           s_done;
    logic [15:0]  ov_hi;
    logic [15:0]  ov_lo;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_outputs_zero("post_reset");

    run_pass("load", 0, 5, 3, 0, 0);

    mem[20][15:0] = 16'd100;
    r = rnd_row();
    r[15:0] = 16'hffe2;
    rows.push_back(r);
    run_pass("acc", 1, 20, 1, 0, 0);
    chk("acc_100_m30", W'(mem[20][15:0]), W'(16'd70));

    mem[21][15:0] = 16'd10;
    r = rnd_row();
    r[15:0] = 16'hffe2;
    rows.push_back(r);
    run_pass("accrelu", 2, 21, 1, 0, 0);
    chk("accrelu_10_m30", W'(mem[21][15:0]), W'(16'd0));

    mem[22][15:0] = 16'hfffb;
    mem[23][15:0] = 16'd7;
    run_pass("relu", 3, 22, 2, 0, 0);
    chk("relu_m5", W'(mem[22][15:0]), W'(16'd0));
    chk("relu_7", W'(mem[23][15:0]), W'(16'd7));

    mem[30][15:0] = 16'h7fff;
    mem[31][15:0] = 16'h8000;
    r = rnd_row();
    r[15:0] = 16'h0001;
    rows.push_back(r);
    r = rnd_row();
    r[15:0] = 16'hffff;
    rows.push_back(r);
    run_pass("ovf", 1, 30, 2, 0, 0);
`ifdef SFP_SAT_EN
    ov_hi = 16'h7fff;
    ov_lo = 16'h8000;
`else
    ov_hi = 16'h8000;
    ov_lo = 16'h7fff;
`endif
    chk("ovf_pos", W'(mem[30][15:0]), W'(ov_hi));
    chk("ovf_neg", W'(mem[31][15:0]), W'(ov_lo));

    run_pass("stall", 1, 40, 6, 1, 0);
    run_pass("len0", 1, 50, 0, 0, 0);
    run_pass("wrap", 0, 2047, 2, 0, 0);

    // abort a pass while row 0 sits in stage 1
    s_wr   = tot_wr;
    s_done = tot_done;
    for (int k = 0; k < 4; k++) fifo_q.push_back(rnd_row());
    @(negedge clk);
    cur_op    = 0;
    pass_base = 100;
    start     = 1'b1;
    op        = 2'd0;
    base_addr = ABW'(100);
    len       = (ABW+1)'(4);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_outputs_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fifo_q.delete();
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_write", W'(tot_wr - s_wr), W'(0));
    chk("abort_no_done", W'(tot_done - s_done), W'(0));
    chk("abort_idle", W'(busy), W'(0));

    run_pass("after_abort", 1, 200, 5, 0, 0);

    for (int i = 0; i < 20; i++)
      run_pass("rand", int'($urandom_range(0, 3)),
               int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(1, 40)), 0,
               1'($urandom_range(0, 1)));

    run_pass("full", 1, int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
